// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory, one transaction in flight.
// Define MEM_ARB_FIXED_PRIO_EN to give the data port fixed priority instead of round-robin.
module mem_arbiter #(
    parameter int unsigned MEMORY_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        if_rready,
    output logic [31:0] if_rdata,
    output logic        if_rerr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [31:0] d_rdata,
    output logic        d_rerr,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        owner_d;
    logic [31:0] rdata_q;
    logic        rerr_q;
    logic [31:0] sel_addr;
    logic        in_range;
    logic        any_gnt;
    logic        owner_ready;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state == IDLE) begin
            d_gnt  = d_req;
            if_gnt = if_req & ~d_req;
        end
    end
`else
    // ptr_d = 1 means the data port wins the next simultaneous request
    logic ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_d <= 1'b1;
        end else if (if_gnt || d_gnt) begin
            ptr_d <= ~d_gnt;
        end
    end

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state == IDLE) begin
            if (d_req && (!if_req || ptr_d)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end
`endif

    assign any_gnt     = if_gnt | d_gnt;
    assign sel_addr    = d_gnt ? d_addr : if_addr;
    assign in_range    = (sel_addr < MEMORY_SIZE);
    assign mem_write   = d_gnt & d_we & in_range;
    assign mem_addr    = any_gnt ? sel_addr : 32'd0;
    assign mem_data_in = any_gnt ? d_wdata : 32'd0;
    assign owner_ready = owner_d ? d_rready : if_rready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (any_gnt) state_next = RESP;
            RESP: if (owner_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stores and out-of-range accesses return zero data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
            owner_d <= 1'b0;
        end else if (state == IDLE && any_gnt) begin
            rdata_q <= ((d_gnt && d_we) || !in_range) ? 32'd0 : mem_data_out;
            rerr_q  <= ~in_range;
            owner_d <= d_gnt;
        end
    end

    assign if_rvalid = (state == RESP) & ~owner_d;
    assign d_rvalid  = (state == RESP) & owner_d;
    assign if_rdata  = if_rvalid ? rdata_q : 32'd0;
    assign d_rdata   = d_rvalid ? rdata_q : 32'd0;
    assign if_rerr   = if_rvalid & rerr_q;
    assign d_rerr    = d_rvalid & rerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model with its own copy of memory contents.
module tb_mem_arbiter;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_rready, d_req, d_we, d_rready;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, if_rerr, d_gnt, d_rvalid, d_rerr, mem_write;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem_arbiter #(.MEMORY_SIZE(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rready(if_rready), .if_rdata(if_rdata), .if_rerr(if_rerr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rdata(d_rdata), .d_rerr(d_rerr),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Behavioural memory_unit: combinational read, write on the rising edge
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        init_mem;

    function automatic logic [31:0] init_word(int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    assign mem_data_out = (mem_addr < 32'(MEM_WORDS)) ? mem[mem_addr[9:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
        end else if (mem_write && mem_addr < 32'(MEM_WORDS)) begin
            mem[mem_addr[9:0]] <= mem_data_in;
        end
    end

    // Transaction-level reference model
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    bit          m_busy, m_owner_d, m_ptr_d, m_rerr, m_last_if_gnt, m_last_d_gnt;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic        obs_if_gnt, obs_d_gnt, obs_mem_write, obs_if_rvalid, obs_d_rvalid;
    logic        obs_if_rerr, obs_d_rerr;
    logic [31:0] obs_if_rdata, obs_d_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic irr,
                                 input logic dr, input logic dwe, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic drr);
        if_req = ir; if_addr = ia; if_rready = irr;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_rready = drr;
    endtask

    // One clock: sample and check at the falling edge, then advance the model at the rising edge
    task automatic runCycle();
        logic        e_ig, e_dg, inr, gnt;
        logic [31:0] a;
        @(negedge clk);
        obs_if_gnt = if_gnt; obs_d_gnt = d_gnt; obs_mem_write = mem_write;
        obs_if_rvalid = if_rvalid; obs_d_rvalid = d_rvalid;
        obs_if_rdata = if_rdata; obs_d_rdata = d_rdata;
        obs_if_rerr = if_rerr; obs_d_rerr = d_rerr;
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (!m_busy) begin
            if (d_req && if_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                e_dg = 1'b1;
`else
                if (m_ptr_d) e_dg = 1'b1;
                else         e_ig = 1'b1;
`endif
            end else if (d_req) begin
                e_dg = 1'b1;
            end else if (if_req) begin
                e_ig = 1'b1;
            end
        end
        gnt = e_ig | e_dg;
        a   = e_dg ? d_addr : if_addr;
        inr = (a < 32'(MEM_WORDS));
        if (rst_n) begin
            checkOutput("if_gnt", {31'd0, if_gnt}, {31'd0, e_ig});
            checkOutput("d_gnt", {31'd0, d_gnt}, {31'd0, e_dg});
            checkOutput("mem_write", {31'd0, mem_write}, {31'd0, e_dg && d_we && inr});
            checkOutput("mem_addr", mem_addr, gnt ? a : 32'd0);
            checkOutput("mem_data_in", mem_data_in, gnt ? d_wdata : 32'd0);
            checkOutput("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_busy && !m_owner_d});
            checkOutput("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_busy && m_owner_d});
            if (m_busy && m_owner_d) begin
                checkOutput("d_rdata", d_rdata, m_rdata);
                checkOutput("d_rerr", {31'd0, d_rerr}, {31'd0, m_rerr});
            end else if (m_busy) begin
                checkOutput("if_rdata", if_rdata, m_rdata);
                checkOutput("if_rerr", {31'd0, if_rerr}, {31'd0, m_rerr});
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr_d = 1'b1;
            m_last_if_gnt = 1'b0;
            m_last_d_gnt = 1'b0;
        end else begin
            m_last_if_gnt = e_ig;
            m_last_d_gnt = e_dg;
            if (gnt) begin
                m_rdata = ((e_dg && d_we) || !inr) ? 32'd0 : ref_mem[a[9:0]];
                m_rerr = !inr;
                if (e_dg && d_we && inr) ref_mem[a[9:0]] = d_wdata;
                m_busy = 1'b1;
                m_owner_d = e_dg;
                m_ptr_d = !e_dg;
            end else if (m_busy && (m_owner_d ? d_rready : if_rready)) begin
                m_busy = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'd1024 + 32'($urandom_range(0, 3));
        if (r == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 31));
    endfunction

    bit          pend_i, pend_d, pd_we, do_rst;
    logic [31:0] pi_addr, pd_addr, pd_wdata;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        m_busy = 1'b0; m_owner_d = 1'b0; m_ptr_d = 1'b1; m_rerr = 1'b0; m_rdata = 32'd0;
        m_last_if_gnt = 1'b0; m_last_d_gnt = 1'b0;
        rst_n = 1'b0;
        init_mem = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();
        init_mem = 1'b0;
        runCycle();
        rst_n = 1'b1;
        runCycle();
        checkOutput("reset d_rdata", obs_d_rdata, 32'd0);
        checkOutput("reset if_rerr", {31'd0, obs_if_rerr}, 32'd0);

        // Single fetch with immediate acceptance
        applyStimulus(1, 32'd5, 1, 0, 0, 0, 0, 0);
        runCycle();
        checkOutput("fetch grant", {31'd0, obs_if_gnt}, 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        runCycle();
        checkOutput("fetch rvalid", {31'd0, obs_if_rvalid}, 32'd1);
        checkOutput("fetch rdata", obs_if_rdata, 32'hDEADBEEF);
        checkOutput("fetch rerr", {31'd0, obs_if_rerr}, 32'd0);
        runCycle();
        checkOutput("fetch idle after", {31'd0, obs_if_rvalid}, 32'd0);

        // Store then load back the same word
        applyStimulus(0, 0, 0, 1, 1, 32'd7, 32'h1234_5678, 1);
        runCycle();
        checkOutput("store mem_write", {31'd0, obs_mem_write}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        runCycle();
        checkOutput("store resp mem_write", {31'd0, obs_mem_write}, 32'd0);
        checkOutput("store resp rdata", obs_d_rdata, 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 32'd7, 32'd0, 1);
        runCycle();
        checkOutput("load mem_write", {31'd0, obs_mem_write}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        runCycle();
        checkOutput("load rdata", obs_d_rdata, 32'h1234_5678);

        // Both ports requesting continuously straight after reset
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic ed, ei;
`ifdef MEM_ARB_FIXED_PRIO_EN
            ed = (k % 2 == 0);
            ei = 1'b0;
`else
            ed = (k % 4 == 0);
            ei = (k % 4 == 2);
`endif
            applyStimulus(1, 32'd16, 1, 1, 0, 32'd17, 32'd0, 1);
            runCycle();
            checkOutput("alternate d_gnt", {31'd0, obs_d_gnt}, {31'd0, ed});
            checkOutput("alternate if_gnt", {31'd0, obs_if_gnt}, {31'd0, ei});
        end

        // Out-of-range store and fetch
        applyStimulus(0, 0, 0, 1, 1, 32'd1024, 32'hCAFE_F00D, 1);
        runCycle();
        checkOutput("oor store grant", {31'd0, obs_d_gnt}, 32'd1);
        checkOutput("oor store mem_write", {31'd0, obs_mem_write}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        runCycle();
        checkOutput("oor store rerr", {31'd0, obs_d_rerr}, 32'd1);
        applyStimulus(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1);
        runCycle();
        checkOutput("oor fetch grant", {31'd0, obs_if_gnt}, 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
        runCycle();
        checkOutput("oor fetch rerr", {31'd0, obs_if_rerr}, 32'd1);
        checkOutput("oor fetch rdata", obs_if_rdata, 32'd0);

        // Backpressure on a load while fetch waits
        applyStimulus(0, 0, 0, 1, 0, 32'd3, 32'd0, 0);
        runCycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 32'd4, 1, 0, 0, 0, 0, 0);
            runCycle();
            checkOutput("stall if_gnt", {31'd0, obs_if_gnt}, 32'd0);
            checkOutput("stall d_rdata", obs_d_rdata, init_word(3));
        end
        applyStimulus(1, 32'd4, 1, 0, 0, 0, 0, 1);
        runCycle();
        checkOutput("accept if_gnt", {31'd0, obs_if_gnt}, 32'd0);
        applyStimulus(1, 32'd4, 1, 0, 0, 0, 0, 0);
        runCycle();
        checkOutput("post-accept if_gnt", {31'd0, obs_if_gnt}, 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        runCycle();

        // Reset while a store response is pending
        applyStimulus(0, 0, 0, 1, 1, 32'd9, 32'h0BAD_CAFE, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        runCycle();
        checkOutput("pre-reset d_rvalid", {31'd0, obs_d_rvalid}, 32'd1);
        rst_n = 1'b1;
        runCycle();
        checkOutput("post-reset d_rvalid", {31'd0, obs_d_rvalid}, 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 32'd9, 32'd0, 1);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        runCycle();
        checkOutput("store survives reset", obs_d_rdata, 32'h0BAD_CAFE);

        // Randomized traffic; requests are held until the model says they were granted
        pend_i = 1'b0; pend_d = 1'b0; pd_we = 1'b0;
        pi_addr = 32'd0; pd_addr = 32'd0; pd_wdata = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            if (m_last_if_gnt) pend_i = 1'b0;
            if (m_last_d_gnt) pend_d = 1'b0;
            do_rst = ($urandom_range(0, 299) == 0);
            if (do_rst) begin
                pend_i = 1'b0;
                pend_d = 1'b0;
            end else begin
                if (!pend_i && $urandom_range(0, 2) == 0) begin
                    pend_i = 1'b1;
                    pi_addr = rand_addr();
                end
                if (!pend_d && $urandom_range(0, 2) == 0) begin
                    pend_d = 1'b1;
                    pd_addr = rand_addr();
                    pd_we = 1'($urandom_range(0, 1));
                    pd_wdata = $urandom;
                end
            end
            rst_n = !do_rst;
            applyStimulus(pend_i, pi_addr, ($urandom_range(0, 9) < 7), pend_d, pd_we, pd_addr,
                          pd_wdata, ($urandom_range(0, 9) < 7));
            runCycle();
        end

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
            checkOutput("memory image", 32'(bad), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
